// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// The low two digits feed the 2-digit BCD adder. ovf flags results above 99.
module bin2bcd_seq #(
  parameter int BIN_W = 8,
  parameter int NDIG  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_W-1:0]     bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NDIG-1:0]    bcd,
  output logic                 ovf
);
  localparam int CW = $clog2(BIN_W+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              r_state;
  logic [BIN_W-1:0]    r_bin;
  logic [4*NDIG-1:0]   r_bcd;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf;
  logic                r_out_valid;
  logic [4*NDIG-1:0]   w_adj;
  logic [4*NDIG-1:0]   w_bcd_nxt;
  logic                w_ovf_nxt;

  // Add-3 correction per digit, then shift the binary MSB into BCD bit 0.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < NDIG; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5)
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
    w_bcd_nxt = {w_adj[4*NDIG-2:0], r_bin[BIN_W-1]};
    w_ovf_nxt = 1'b0;
    for (int k = 2; k < NDIG; k++)
      w_ovf_nxt = w_ovf_nxt | (|w_bcd_nxt[4*k +: 4]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bin   <= bin;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(BIN_W-1)) begin
            r_state     <= DONE;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Counter holds at BIN_W; result stays frozen until the handoff.
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign bcd       = r_bcd;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (BIN_W=8, NDIG=3).
module tb_bin2bcd_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  bin2bcd_seq #(.BIN_W(8), .NDIG(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference 2-digit BCD adder (cin=0) used to show the operand is adder-ready.
  function automatic logic [8:0] bcd_add8(input logic [7:0] a, input logic [7:0] b);
    logic [4:0] lo;
    logic [4:0] hi;
    logic       c;
    lo = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    c  = 1'b0;
    if (lo > 5'd9) begin lo = lo + 5'd6; c = 1'b1; end
    hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, c};
    c  = 1'b0;
    if (hi > 5'd9) begin hi = hi + 5'd6; c = 1'b1; end
    return {c, hi[3:0], lo[3:0]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin = 8'd0;
    tick(); tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (bcd !== 12'h000) begin bad++; $display("FAIL reset_bcd got=%h want=000", bcd); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    rst_n = 1'b1;
    tick();
  endtask

  // Accept b, wait for out_valid (bounded), check latency and result; optionally hand off.
  task automatic convert(input logic [7:0] b, input logic [11:0] exp_bcd, input logic exp_ovf,
                         input bit handoff);
    int n;
    bin = b; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (n != 8) begin bad++; $display("FAIL latency bin=%0d got=%0d want=8", b, n); end
    total++; if (bcd !== exp_bcd) begin bad++; $display("FAIL bcd bin=%0d got=%h want=%h", b, bcd, exp_bcd); end
    total++; if (ovf !== exp_ovf) begin bad++; $display("FAIL ovf bin=%0d got=%b want=%b", b, ovf, exp_ovf); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL done_in_ready bin=%0d got=%b want=0", b, in_ready); end
    if (handoff) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++; $display("FAIL handoff bin=%0d got in_ready=%b out_valid=%b want 1/0", b, in_ready, out_valid);
      end
      total++; if (bcd !== exp_bcd) begin bad++; $display("FAIL bcd_hold bin=%0d got=%h want=%h", b, bcd, exp_bcd); end
    end
  endtask

  task automatic test_values();
    logic [8:0] s;
    convert(8'd0,   12'h000, 1'b0, 1'b1);
    convert(8'd99,  12'h099, 1'b0, 1'b1);
    convert(8'd49,  12'h049, 1'b0, 1'b1);
    s = bcd_add8(bcd[7:0], bcd[7:0]);
    total++; if (s !== 9'h098) begin bad++; $display("FAIL adder_feed got=%h want=098", s); end
    convert(8'd100, 12'h100, 1'b1, 1'b1);
    convert(8'd255, 12'h255, 1'b1, 1'b1);
    convert(8'd58,  12'h058, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    convert(8'd37, 12'h037, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bin = 8'(8'hA5 ^ i); in_valid = i[0];
      tick();
      total++; if (bcd !== 12'h037 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL backpressure cyc=%0d got bcd=%h ov=%b ir=%b want 037/1/0", i, bcd, out_valid, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got ir=%b ov=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bin = 8'd200; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (in_ready !== 1'b1 || bcd !== 12'h000 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid got ir=%b bcd=%h ov=%b want 1/000/0", in_ready, bcd, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); if (out_valid === 1'b1) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_no_valid got=%b want=0", seen); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int          t[2];
    logic [11:0] r[2];
    int          np;
    out_ready = 1'b1; in_valid = 1'b1; bin = 8'd9;
    tick();
    bin = 8'd91;
    np = 0; t[0] = -1; t[1] = -1; r[0] = '0; r[1] = '0;
    for (int i = 1; i < 26; i++) begin
      if (out_valid === 1'b1) begin
        if (np < 2) begin t[np] = i; r[np] = bcd; end
        np++;
      end
      tick();
    end
    in_valid = 1'b0;
    total++; if (np != 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", np); end
    total++; if (r[0] !== 12'h009) begin bad++; $display("FAIL b2b_first got=%h want=009", r[0]); end
    total++; if (r[1] !== 12'h091) begin bad++; $display("FAIL b2b_second got=%h want=091", r[1]); end
    total++; if (t[1] - t[0] != 10) begin bad++; $display("FAIL b2b_spacing got=%0d want=10", t[1] - t[0]); end
    np = 0;
    while (in_ready !== 1'b1 && np < 20) begin tick(); np++; end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_drain got=%b want=1", in_ready); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_values();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
